// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execute-stage ALU and the ID-stage control unit.
//   alu_ctrl_e  : 4-bit ALU control codes driven on ctrl
//   alu_op_e    : 2-bit ALU operation class from the control unit
//   F3_B*       : branch funct3 encodings
//   funct3_ctrl : default funct3 -> control-code map shared by R- and I-type
package alu_exec_unit_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_MUL  = 4'b1010
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // funct3 map common to register and immediate ALU instructions.
    function automatic alu_ctrl_e funct3_ctrl(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/add32.sv
// 32-bit adder for pc + imm; carry out is discarded.
//   a, b [31:0] : addends
//   sum  [31:0] : a + b modulo 2^32
module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/alu_core.sv
// ALU datapath: operation select, zero flag, branch compare, full product.
//   reset          : forces result/zero_flag/branch low
//   alu_op, funct3 : branch qualification and condition select
//   ctrl   [3:0]   : control code from alu_ctrl_decode
//   data0, data1   : operands
//   result [31:0]  : ALU result
//   zero_flag      : result == 0
//   branch         : branch condition (only when alu_op is branch compare)
//   product[63:0]  : signed data0 * data1, registered by the top level
module alu_core
    import alu_exec_unit_pkg::*;
(
    input  logic        reset,
    input  logic [1:0]  alu_op,
    input  logic [2:0]  funct3,
    input  logic [3:0]  ctrl,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic [31:0] result,
    output logic        zero_flag,
    output logic        branch,
    output logic [63:0] product
);

    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;
    logic        eq;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [31:0] alu_val;
    logic        br_cond;

    assign shamt = data1[4:0];
    assign lt_s  = $signed(data0) < $signed(data1);
    assign lt_u  = data0 < data1;
    assign eq    = data0 == data1;

    // Sign-extending to 64 bits first makes the low 64 bits of an unsigned
    // multiply equal to the signed 32x32 product.
    assign a_ext   = {{32{data0[31]}}, data0};
    assign b_ext   = {{32{data1[31]}}, data1};
    assign product = a_ext * b_ext;

    always_comb begin
        alu_val = '0;
        case (ctrl)
            ALU_AND:  alu_val = data0 & data1;
            ALU_OR:   alu_val = data0 | data1;
            ALU_ADD:  alu_val = data0 + data1;
            ALU_XOR:  alu_val = data0 ^ data1;
            ALU_SLL:  alu_val = data0 << shamt;
            ALU_SRL:  alu_val = data0 >> shamt;
            ALU_SUB:  alu_val = data0 - data1;
            ALU_SRA:  alu_val = $signed(data0) >>> shamt;
            ALU_SLT:  alu_val = {31'b0, lt_s};
            ALU_SLTU: alu_val = {31'b0, lt_u};
            ALU_MUL:  alu_val = product[31:0];
            default:  alu_val = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            F3_BEQ:  br_cond = eq;
            F3_BNE:  br_cond = !eq;
            F3_BLT:  br_cond = lt_s;
            F3_BGE:  br_cond = !lt_s;
            F3_BLTU: br_cond = lt_u;
            F3_BGEU: br_cond = !lt_u;
            default: br_cond = 1'b0;
        endcase
    end

    assign result    = reset ? 32'b0 : alu_val;
    assign zero_flag = !reset && (alu_val == 32'b0);
    assign branch    = !reset && (alu_op == ALUOP_BRANCH) && br_cond;

endmodule

// File: rtl/alu_ctrl_decode.sv
// ALU control decode: alu_op/funct3/funct7 -> 4-bit control code.
//   alu_op [1:0] : operation class
//   funct3 [2:0] : instruction[14:12]
//   funct7 [6:0] : instruction[31:25]
//   ctrl   [3:0] : decoded control code (alu_ctrl_e)
module alu_ctrl_decode
    import alu_exec_unit_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] ctrl
);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:    ctrl = ALU_ADD;
            ALUOP_BRANCH: ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                if (funct7 == FUNCT7_MULDIV && funct3 == 3'b000)
                    ctrl = ALU_MUL;
                else if (funct7[5] && funct3 == 3'b000)
                    ctrl = ALU_SUB;
                else if (funct7[5] && funct3 == 3'b101)
                    ctrl = ALU_SRA;
                else
                    ctrl = funct3_ctrl(funct3);
            end
            default: begin
                // Immediate forms: ADDI has no SUB variant, only SRAI looks at funct7.
                if (funct7[5] && funct3 == 3'b101)
                    ctrl = ALU_SRA;
                else
                    ctrl = funct3_ctrl(funct3);
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage arithmetic block of the RV32IM pipeline.
//   clk, reset           : pipeline clock, async active-high reset
//   alu_op/funct3/funct7 : decode inputs
//   data0, data1         : forwarded operands
//   pc, imm              : PC and sign-extended immediate
//   ctrl                 : decoded ALU control code
//   result, zero_flag    : ALU result and result==0
//   branch               : branch taken (alu_op = branch compare)
//   pc_plus_imm          : pc + imm
//   mul_res              : registered 64-bit product of the last MUL
module alu_exec_unit
    import alu_exec_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  alu_op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic [3:0]  ctrl,
    output logic [31:0] result,
    output logic        zero_flag,
    output logic        branch,
    output logic [31:0] pc_plus_imm,
    output logic [63:0] mul_res
);

    logic [63:0] product;

    alu_ctrl_decode u_decode (
        .alu_op (alu_op),
        .funct3 (funct3),
        .funct7 (funct7),
        .ctrl   (ctrl)
    );

    alu_core u_core (
        .reset     (reset),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .ctrl      (ctrl),
        .data0     (data0),
        .data1     (data1),
        .result    (result),
        .zero_flag (zero_flag),
        .branch    (branch),
        .product   (product)
    );

    add32 u_pc_add (
        .a   (pc),
        .b   (imm),
        .sum (pc_plus_imm)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mul_res <= '0;
        else if (ctrl == ALU_MUL)
            mul_res <= product;
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  ctrl;
    logic [31:0] result;
    logic        zero_flag;
    logic        branch;
    logic [31:0] pc_plus_imm;
    logic [63:0] mul_res;

    int total = 0;
    int bad   = 0;

    alu_exec_unit dut (
        .clk         (clk),
        .reset       (reset),
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7      (funct7),
        .data0       (data0),
        .data1       (data1),
        .pc          (pc),
        .imm         (imm),
        .ctrl        (ctrl),
        .result      (result),
        .zero_flag   (zero_flag),
        .branch      (branch),
        .pc_plus_imm (pc_plus_imm),
        .mul_res     (mul_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Applies one vector just after a falling edge, then lets it settle.
    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_op = op;
        funct3 = f3;
        funct7 = f7;
        data0  = a;
        data1  = b;
        #1;
    endtask

    task automatic check_alu(input string tag, input logic [3:0] exp_ctrl,
                             input logic [31:0] exp_res, input logic exp_zero);
        check({tag, ".ctrl"}, 64'(ctrl), 64'(exp_ctrl));
        check({tag, ".result"}, 64'(result), 64'(exp_res));
        check({tag, ".zero"}, 64'(zero_flag), 64'(exp_zero));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        alu_op = 2'b00;
        funct3 = 3'b000;
        funct7 = 7'b0000000;
        data0  = 32'd5;
        data1  = 32'd7;
        pc     = 32'h0000_0FFC;
        imm    = 32'h0000_0008;
        #1;
        // Reset state: outputs forced low, ctrl and pc adder still live.
        check("rst.mul_res", mul_res, 64'h0);
        check("rst.result", 64'(result), 64'h0);
        check("rst.zero", 64'(zero_flag), 64'h0);
        check("rst.branch", 64'(branch), 64'h0);
        check("rst.ctrl", 64'(ctrl), 64'h2);
        check("rst.pc_plus_imm", 64'(pc_plus_imm), 64'h0000_1004);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_exit.result", 64'(result), 64'hC);

        // R-type SUB / ADD
        drive(2'b10, 3'b000, 7'b0100000, 32'd5, 32'd7);
        check_alu("sub", 4'b0110, 32'hFFFF_FFFE, 1'b0);
        drive(2'b10, 3'b000, 7'b0000000, 32'd5, 32'd7);
        check_alu("add", 4'b0010, 32'h0000_000C, 1'b0);
        // ADDI ignores funct7[5]
        drive(2'b11, 3'b000, 7'b0100000, 32'd5, 32'd7);
        check_alu("addi_f7", 4'b0010, 32'h0000_000C, 1'b0);

        // Shifts: only data1[4:0] used
        drive(2'b11, 3'b101, 7'b0100000, 32'h8000_0000, 32'h0000_0024);
        check_alu("srai", 4'b0111, 32'hF800_0000, 1'b0);
        drive(2'b11, 3'b101, 7'b0000000, 32'h8000_0000, 32'h0000_0024);
        check_alu("srli", 4'b0101, 32'h0800_0000, 1'b0);
        drive(2'b10, 3'b001, 7'b0000000, 32'h0000_0001, 32'h0000_0021);
        check_alu("sll", 4'b0100, 32'h0000_0002, 1'b0);

        // Compares
        drive(2'b10, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'h0000_0001);
        check_alu("slt", 4'b1000, 32'h0000_0001, 1'b0);
        drive(2'b10, 3'b011, 7'b0000000, 32'hFFFF_FFFF, 32'h0000_0001);
        check_alu("sltu", 4'b1001, 32'h0000_0000, 1'b1);

        // Logic ops; funct7=0000001 with funct3!=000 falls back to funct3 map
        drive(2'b10, 3'b111, 7'b0000000, 32'h0000_F0F0, 32'h0000_FF00);
        check_alu("and", 4'b0000, 32'h0000_F000, 1'b0);
        drive(2'b11, 3'b110, 7'b0000000, 32'h0000_F0F0, 32'h0000_FF00);
        check_alu("ori", 4'b0001, 32'h0000_FFF0, 1'b0);
        drive(2'b10, 3'b100, 7'b0000001, 32'hFFFF_FFFE, 32'h0000_0003);
        check_alu("div_as_xor", 4'b0011, 32'hFFFF_FFFD, 1'b0);

        // Branches
        drive(2'b01, 3'b000, 7'b0000000, 32'h0000_1234, 32'h0000_1234);
        check_alu("beq", 4'b0110, 32'h0, 1'b1);
        check("beq.branch", 64'(branch), 64'h1);
        drive(2'b01, 3'b110, 7'b0000000, 32'h0000_0001, 32'hFFFF_FFFF);
        check("bltu.branch", 64'(branch), 64'h1);
        check("bltu.result", 64'(result), 64'h2);
        drive(2'b01, 3'b100, 7'b0000000, 32'h0000_0001, 32'hFFFF_FFFF);
        check("blt.branch", 64'(branch), 64'h0);
        drive(2'b01, 3'b101, 7'b0000000, 32'h0000_0001, 32'hFFFF_FFFF);
        check("bge.branch", 64'(branch), 64'h1);
        drive(2'b01, 3'b111, 7'b0000000, 32'h0000_0001, 32'hFFFF_FFFF);
        check("bgeu.branch", 64'(branch), 64'h0);
        drive(2'b01, 3'b001, 7'b0000000, 32'h0000_0001, 32'hFFFF_FFFF);
        check("bne.branch", 64'(branch), 64'h1);
        drive(2'b01, 3'b010, 7'b0000000, 32'h0000_0005, 32'h0000_0005);
        check("b010.branch", 64'(branch), 64'h0);
        drive(2'b00, 3'b000, 7'b0000000, 32'h0000_0001, 32'hFFFF_FFFF);
        check("op00.branch", 64'(branch), 64'h0);
        check_alu("op00_wrap", 4'b0010, 32'h0, 1'b1);

        // MUL: combinational low word, registered product on next edge
        drive(2'b10, 3'b000, 7'b0000001, 32'hFFFF_FFFE, 32'h0000_0003);
        check_alu("mul", 4'b1010, 32'hFFFF_FFFA, 1'b0);
        check("mul.pre_edge", mul_res, 64'h0);
        @(posedge clk);
        #1;
        check("mul.reg", mul_res, 64'hFFFF_FFFF_FFFF_FFFA);
        drive(2'b00, 3'b000, 7'b0000000, 32'h0000_0003, 32'h0000_0004);
        @(posedge clk);
        #1;
        check("mul.hold1", mul_res, 64'hFFFF_FFFF_FFFF_FFFA);
        drive(2'b10, 3'b000, 7'b0100000, 32'h0000_0003, 32'h0000_0004);
        @(posedge clk);
        #1;
        check("mul.hold2", mul_res, 64'hFFFF_FFFF_FFFF_FFFA);

        // Reset between edges: async clear and forced outputs
        drive(2'b01, 3'b000, 7'b0000000, 32'h0000_1234, 32'h0000_1234);
        pc  = 32'h0000_0FFC;
        imm = 32'h0000_0008;
        reset = 1'b1;
        #1;
        check("midrst.mul_res", mul_res, 64'h0);
        check("midrst.result", 64'(result), 64'h0);
        check("midrst.zero", 64'(zero_flag), 64'h0);
        check("midrst.branch", 64'(branch), 64'h0);
        check("midrst.ctrl", 64'(ctrl), 64'h6);
        check("midrst.pc_plus_imm", 64'(pc_plus_imm), 64'h0000_1004);
        reset = 1'b0;
        #1;
        check("postrst.branch", 64'(branch), 64'h1);
        check("postrst.zero", 64'(zero_flag), 64'h1);
        check("postrst.pc_plus_imm", 64'(pc_plus_imm), 64'h0000_1004);
        @(posedge clk);
        #1;
        check("postrst.mul_res", mul_res, 64'h0);

        // Wraparound
        drive(2'b00, 3'b000, 7'b0000000, 32'hFFFF_FFFF, 32'h0000_0001);
        pc  = 32'hFFFF_FFFC;
        imm = 32'h0000_0008;
        #1;
        check_alu("add_wrap", 4'b0010, 32'h0, 1'b1);
        check("pc_wrap", 64'(pc_plus_imm), 64'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
